mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the core's instruction-fetch requester (I) and load/store requester (D).
- Three-state controller: accepts a request, drives the memory port until the memory reports completion or a watchdog expires, then returns a one-cycle acknowledge.
- D wins by default. A starvation counter forces an I grant after STARVE_MAX consecutive D grants made while I was waiting.
- Sits between the core's fetch/memory stages and the memory macro.

---
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch (I) and
// load/store (D); D has priority, a starvation counter forces an occasional I grant.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned TO_W       = 8
) (
    input  logic        i_Clk,
    input  logic        i_Rst,

    input  logic        i_I_Req,
    input  logic [31:0] i_I_Addr,
    output logic        o_I_Ack,
    output logic [31:0] o_I_RData,
    output logic        o_I_Err,

    input  logic        i_D_Req,
    input  logic        i_D_WE,
    input  logic [1:0]  i_D_Size,
    input  logic [31:0] i_D_Addr,
    input  logic [31:0] i_D_WData,
    output logic        o_D_Ack,
    output logic [31:0] o_D_RData,
    output logic        o_D_Err,

    output logic        o_Mem_Req,
    output logic        o_Mem_WE,
    output logic [1:0]  o_Mem_Size,
    output logic [31:0] o_Mem_Addr,
    output logic [31:0] o_Mem_WData,
    input  logic        i_Mem_Done,
    input  logic [31:0] i_Mem_RData,

    output logic        o_Busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] SCNT_MAX  = CNT_W'(STARVE_MAX);
    localparam logic [TO_W-1:0]  WD_MAX    = TO_W'(TIMEOUT);
    localparam logic [1:0]       SIZE_WORD = 2'b10;

    state_e            state_q;
    logic              owner_d_q;
    logic [CNT_W-1:0]  scnt_q;
    logic [TO_W-1:0]   wd_q;

    logic              mem_req_q;
    logic              mem_we_q;
    logic [1:0]        mem_size_q;
    logic [31:0]       mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic              i_ack_q;
    logic [31:0]       i_rdata_q;
    logic              i_err_q;
    logic              d_ack_q;
    logic [31:0]       d_rdata_q;
    logic              d_err_q;
    logic              busy_q;

    logic              grant_i_d;
    logic              grant_d_d;
    logic [CNT_W-1:0]  scnt_d;
    logic              finish_d;
    logic [31:0]       resp_data_d;

    // Grant decision and starvation bookkeeping; only meaningful in IDLE.
    always_comb begin
        grant_i_d = 1'b0;
        grant_d_d = 1'b0;
        scnt_d    = scnt_q;
        if (state_q == S_IDLE) begin
            if (i_I_Req && (!i_D_Req || scnt_q == SCNT_MAX)) begin
                grant_i_d = 1'b1;
                scnt_d    = '0;
            end else if (i_D_Req) begin
                grant_d_d = 1'b1;
                if (!i_I_Req) begin
                    scnt_d = '0;
                end else if (scnt_q != SCNT_MAX) begin
                    scnt_d = scnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Completion wins over the watchdog when both happen in the same cycle.
    always_comb begin
        finish_d    = i_Mem_Done || (wd_q == WD_MAX);
        resp_data_d = (i_Mem_Done && !mem_we_q) ? i_Mem_RData : '0;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= S_IDLE;
            owner_d_q   <= 1'b0;
            scnt_q      <= '0;
            wd_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            i_err_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            scnt_q  <= scnt_d;
            case (state_q)
                S_IDLE: begin
                    if (grant_i_d || grant_d_d) begin
                        state_q   <= S_ISSUE;
                        owner_d_q <= grant_d_d;
                        busy_q    <= 1'b1;
                        mem_req_q <= 1'b1;
                        wd_q      <= TO_W'(1);
                        if (grant_d_d) begin
                            mem_we_q    <= i_D_WE;
                            mem_size_q  <= i_D_Size;
                            mem_addr_q  <= i_D_Addr;
                            mem_wdata_q <= i_D_WData;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_size_q  <= SIZE_WORD;
                            mem_addr_q  <= i_I_Addr;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (finish_d) begin
                        state_q   <= S_RESP;
                        mem_req_q <= 1'b0;
                        if (owner_d_q) begin
                            d_ack_q   <= 1'b1;
                            d_rdata_q <= resp_data_d;
                            d_err_q   <= !i_Mem_Done;
                        end else begin
                            i_ack_q   <= 1'b1;
                            i_rdata_q <= resp_data_d;
                            i_err_q   <= !i_Mem_Done;
                        end
                    end else begin
                        wd_q <= wd_q + TO_W'(1);
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    wd_q    <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_I_Ack     = i_ack_q;
    assign o_I_RData   = i_rdata_q;
    assign o_I_Err     = i_err_q;
    assign o_D_Ack     = d_ack_q;
    assign o_D_RData   = d_rdata_q;
    assign o_D_Err     = d_err_q;
    assign o_Mem_Req   = mem_req_q;
    assign o_Mem_WE    = mem_we_q;
    assign o_Mem_Size  = mem_size_q;
    assign o_Mem_Addr  = mem_addr_q;
    assign o_Mem_WData = mem_wdata_q;
    assign o_Busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table of single transactions, scoreboarded
// acks, plus sequences for contention, watchdog and reset corner cases.
module tb_mem_port_arbiter;

    localparam logic [31:0] KEY    = 32'h5A5A_5A5A;
    localparam logic [31:0] I_ADDR = 32'h0000_1000;
    localparam logic [31:0] D_ADDR = 32'h0000_2000;

    logic        clk;
    logic        i_Rst;
    logic        i_I_Req;
    logic [31:0] i_I_Addr;
    logic        o_I_Ack;
    logic [31:0] o_I_RData;
    logic        o_I_Err;
    logic        i_D_Req;
    logic        i_D_WE;
    logic [1:0]  i_D_Size;
    logic [31:0] i_D_Addr;
    logic [31:0] i_D_WData;
    logic        o_D_Ack;
    logic [31:0] o_D_RData;
    logic        o_D_Err;
    logic        o_Mem_Req;
    logic        o_Mem_WE;
    logic [1:0]  o_Mem_Size;
    logic [31:0] o_Mem_Addr;
    logic [31:0] o_Mem_WData;
    logic        i_Mem_Done;
    logic [31:0] i_Mem_RData;
    logic        o_Busy;

    mem_port_arbiter #(
        .STARVE_MAX(4),
        .CNT_W     (4),
        .TIMEOUT   (64),
        .TO_W      (8)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (i_Rst),
        .i_I_Req    (i_I_Req),
        .i_I_Addr   (i_I_Addr),
        .o_I_Ack    (o_I_Ack),
        .o_I_RData  (o_I_RData),
        .o_I_Err    (o_I_Err),
        .i_D_Req    (i_D_Req),
        .i_D_WE     (i_D_WE),
        .i_D_Size   (i_D_Size),
        .i_D_Addr   (i_D_Addr),
        .i_D_WData  (i_D_WData),
        .o_D_Ack    (o_D_Ack),
        .o_D_RData  (o_D_RData),
        .o_D_Err    (o_D_Err),
        .o_Mem_Req  (o_Mem_Req),
        .o_Mem_WE   (o_Mem_WE),
        .o_Mem_Size (o_Mem_Size),
        .o_Mem_Addr (o_Mem_Addr),
        .o_Mem_WData(o_Mem_WData),
        .i_Mem_Done (i_Mem_Done),
        .i_Mem_RData(i_Mem_RData),
        .o_Busy     (o_Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_rdata;
        int          delay;      // ISSUE cycle carrying Done; 0 = never
        int          exp_issue;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[8];
    int          total = 0;
    int          bad   = 0;
    int          issue_cnt = 0;
    int          last_issue = 0;
    int          mem_delay = 0;
    bit          use_addr = 1'b0;
    logic [31:0] cur_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory responder: one negedge per call, drives Done/RData for the next edge.
    task automatic tick();
        @(negedge clk);
        if (o_Mem_Req === 1'b1) begin
            issue_cnt++;
        end else if (issue_cnt != 0) begin
            last_issue = issue_cnt;
            issue_cnt  = 0;
        end
        i_Mem_Done  = (o_Mem_Req === 1'b1) && (mem_delay != 0) && (issue_cnt == mem_delay);
        i_Mem_RData = i_Mem_Done ? (use_addr ? (o_Mem_Addr ^ KEY) : cur_rdata) : 32'hBAD0_BAD0;
    endtask

    always @(negedge clk) begin
        if (o_I_Ack === 1'b1 || o_D_Ack === 1'b1) begin
            check("ack_overlap", {31'd0, o_I_Ack & o_D_Ack}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'd0, o_I_Ack, o_D_Ack}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_owner", {31'd0, o_D_Ack}, {31'd0, e.is_d});
                check("ack_rdata", o_D_Ack ? o_D_RData : o_I_RData, e.rdata);
                check("ack_err", {31'd0, o_D_Ack ? o_D_Err : o_I_Err}, {31'd0, e.err});
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, {31'd0, o_Mem_Req}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, o_Mem_WE}, 32'd0);
        check({tag, "_mem_size"}, {30'd0, o_Mem_Size}, 32'd0);
        check({tag, "_mem_addr"}, o_Mem_Addr, 32'd0);
        check({tag, "_mem_wdata"}, o_Mem_WData, 32'd0);
        check({tag, "_acks"}, {30'd0, o_I_Ack, o_D_Ack}, 32'd0);
        check({tag, "_errs"}, {30'd0, o_I_Err, o_D_Err}, 32'd0);
        check({tag, "_i_rdata"}, o_I_RData, 32'd0);
        check({tag, "_d_rdata"}, o_D_RData, 32'd0);
        check({tag, "_busy"}, {31'd0, o_Busy}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        bit   seen = 1'b0;
        bit   got  = 1'b0;
        e.is_d = v.is_d; e.rdata = v.exp_rdata; e.err = v.exp_err;
        sb.push_back(e);
        mem_delay = v.delay; cur_rdata = v.mem_rdata; use_addr = 1'b0;
        if (v.is_d) begin
            i_D_Req = 1'b1; i_D_WE = v.we; i_D_Size = v.size;
            i_D_Addr = v.addr; i_D_WData = v.wdata;
        end else begin
            i_I_Req = 1'b1; i_I_Addr = v.addr;
        end
        for (int c = 0; c < 200 && !got; c++) begin
            tick();
            if (o_Mem_Req === 1'b1) begin
                if (!seen) begin
                    seen = 1'b1;
                    check("grant_latency", c, 0);
                    check("mem_we", {31'd0, o_Mem_WE}, {31'd0, v.is_d ? v.we : 1'b0});
                    check("mem_size", {30'd0, o_Mem_Size}, {30'd0, v.is_d ? v.size : 2'b10});
                    check("mem_wdata", o_Mem_WData, v.is_d ? v.wdata : 32'd0);
                end
                check("mem_addr", o_Mem_Addr, v.addr);
                check("busy_issue", {31'd0, o_Busy}, 32'd1);
            end
            if (o_I_Ack === 1'b1 || o_D_Ack === 1'b1) begin
                got = 1'b1;
                check("ack_latency", c, v.exp_issue);
                check("issue_cycles", last_issue, v.exp_issue);
                i_I_Req = 1'b0; i_D_Req = 1'b0;
            end
        end
        if (!got) begin
            check("ack_timeout", 32'd0, 32'd1);
            i_I_Req = 1'b0; i_D_Req = 1'b0;
        end
        tick();
        check("busy_after", {31'd0, o_Busy}, 32'd0);
    endtask

    // Both requesters held; expected grant order D,D,D,D,I repeating from scnt=0.
    task automatic contention(input int n_acks, input bit drop_after);
        int acks = 0;
        for (int k = 0; k < n_acks; k++) begin
            exp_t e;
            e.is_d  = ((k % 5) != 4);
            e.rdata = e.is_d ? (D_ADDR ^ KEY) : (I_ADDR ^ KEY);
            e.err   = 1'b0;
            sb.push_back(e);
        end
        mem_delay = 1; use_addr = 1'b1;
        i_I_Req = 1'b1; i_I_Addr = I_ADDR;
        i_D_Req = 1'b1; i_D_WE = 1'b0; i_D_Size = 2'b10; i_D_Addr = D_ADDR; i_D_WData = '0;
        for (int c = 0; c < 300 && acks < n_acks; c++) begin
            tick();
            if (o_I_Ack === 1'b1 || o_D_Ack === 1'b1) acks++;
        end
        check("contention_acks", acks, n_acks);
        if (drop_after) begin
            i_I_Req = 1'b0; i_D_Req = 1'b0;
        end
    endtask

    initial begin
        i_Rst = 1'b1; i_I_Req = 1'b0; i_I_Addr = '0;
        i_D_Req = 1'b0; i_D_WE = 1'b0; i_D_Size = '0; i_D_Addr = '0; i_D_WData = '0;
        i_Mem_Done = 1'b0; i_Mem_RData = '0;

        //            is_d  we    size   addr          wdata         mem_rdata     dly iss exp_rdata     err
        vecs[0] = '{1'b0, 1'b1, 2'b01, 32'h0000_0100, 32'h1111_1111, 32'hDEAD_BEEF, 2,  2,  32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 2'b00, 32'h0000_0203, 32'h0000_00AB, 32'h1234_5678, 1,  1,  32'h0000_0000, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 2'b01, 32'h0000_0402, 32'h0000_0000, 32'hCAFE_1234, 3,  3,  32'hCAFE_1234, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 2'b10, 32'h0000_0800, 32'h0000_0000, 32'h7777_7777, 0,  64, 32'h0000_0000, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 2'b00, 32'h0000_0000, 32'h0000_0000, 32'h1357_9BDF, 1,  1,  32'h1357_9BDF, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 2'b10, 32'h0000_0C00, 32'h0000_0000, 32'h0BAD_F00D, 64, 64, 32'h0BAD_F00D, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 2'b00, 32'h0000_0F00, 32'h0000_0000, 32'h5555_AAAA, 0,  64, 32'h0000_0000, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 2'b10, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h9999_0000, 5,  5,  32'h0000_0000, 1'b0};

        tick(); tick();
        i_Rst = 1'b0;
        check_all_zero("reset");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Done while idle must be ignored.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i_Mem_Done = 1'b1; i_Mem_RData = 32'h0000_0077;
            check("idle_done_ack", {30'd0, o_I_Ack, o_D_Ack}, 32'd0);
            check("idle_done_busy", {31'd0, o_Busy}, 32'd0);
        end
        @(negedge clk);
        i_Mem_Done = 1'b0;
        check("idle_done_ack_end", {30'd0, o_I_Ack, o_D_Ack}, 32'd0);

        contention(10, 1'b1);
        tick();

        // Reset during the 4th contested D access must also clear the starvation count.
        contention(3, 1'b0);
        mem_delay = 0;
        for (int c = 0; c < 10 && o_Mem_Req !== 1'b1; c++) tick();
        check("rst_a_owner_addr", o_Mem_Addr, D_ADDR);
        i_Rst = 1'b1;
        tick();
        i_Rst = 1'b0;
        check_all_zero("rst_a");
        contention(5, 1'b1);
        tick();

        // Reset mid D access with I waiting: I granted in the first IDLE cycle.
        mem_delay = 0; use_addr = 1'b1;
        i_D_Req = 1'b1; i_D_WE = 1'b0; i_D_Size = 2'b10; i_D_Addr = 32'h0000_2400;
        for (int c = 0; c < 10 && o_Mem_Req !== 1'b1; c++) tick();
        check("rst_b_d_issue", o_Mem_Addr, 32'h0000_2400);
        i_I_Req = 1'b1; i_I_Addr = 32'h0000_3000;
        tick(); tick();
        i_Rst = 1'b1; i_D_Req = 1'b0;
        tick();
        i_Rst = 1'b0;
        check("rst_b_mem_req", {31'd0, o_Mem_Req}, 32'd0);
        check("rst_b_d_ack", {31'd0, o_D_Ack}, 32'd0);
        check("rst_b_busy", {31'd0, o_Busy}, 32'd0);
        begin
            exp_t e;
            e.is_d = 1'b0; e.rdata = 32'h0000_3000 ^ KEY; e.err = 1'b0;
            sb.push_back(e);
        end
        mem_delay = 1;
        tick();
        check("rst_b_i_grant", {31'd0, o_Mem_Req}, 32'd1);
        check("rst_b_i_addr", o_Mem_Addr, 32'h0000_3000);
        tick();
        check("rst_b_i_ack", {31'd0, o_I_Ack}, 32'd1);
        i_I_Req = 1'b0;
        tick();
        check("rst_b_busy_end", {31'd0, o_Busy}, 32'd0);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
